imem_fetch_ctrl: RTL and testbench



---
 rtl/imem_fetch_ctrl_pkg.sv | 22 ++
 rtl/imem_fetch_ctrl_if.sv | 19 +
 rtl/imem_fetch_ctrl_fifo.sv | 59 +++++
 rtl/imem_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared fetch types and constants for the RV32I instruction-fetch slice.
package riscv_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Decode handshake plus execute redirect bundle of the fetch controller.
interface imem_fetch_ctrl_if;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output out_valid, out_instr, out_pc,
      input  out_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  out_valid, out_instr, out_pc,
      output out_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/imem_fetch_ctrl_fifo.sv
// fetch_fifo: synchronous FIFO with flush; head data reads 0 when empty.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == {(AW+1){1'b0}});
   assign full    = (count == CNT_FULL);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? {WIDTH{1'b0}} : store[rd_ptr];

   // Pointer and occupancy tracking; flush empties the queue in one edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= {AW{1'b0}};
         wr_ptr <= {AW{1'b0}};
         count  <= {(AW+1){1'b0}};
      end else if (flush) begin
         rd_ptr <= {AW{1'b0}};
         wr_ptr <= {AW{1'b0}};
         count  <= {(AW+1){1'b0}};
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are qualified by count so it needs no reset.
   always_ff @(posedge clk) begin
      if (do_push && !flush) store[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// RV32I fetch sequencer: PC, range check, redirect and prefetch buffering.
// Optional build macro FETCH_ZERO_HALT_EN halts fetch on an all-zero word.
module imem_fetch_ctrl
   import riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          DEPTH      = 2,
   parameter int          IMEM_WORDS = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fetch_en,
   output logic [31:0]            imem_addr,
   input  logic [31:0]            imem_rd,
   imem_fetch_ctrl_if.master      bus,
   output logic                   fault,
   output logic                   halted,
   output logic [$clog2(DEPTH):0] fifo_count
);
   localparam logic [31:0] WORDS_LIMIT = 32'(IMEM_WORDS);

   fetch_state_t state, state_next;
   logic [31:0]  pc, pc_next;
   logic         fault_next, halted_next;
   logic         in_range, zero_word, room, fetch_try;
   logic         range_err, zero_hit, push, pop, full, empty;
   fetch_entry_t wentry, head;

   assign imem_addr = {2'b00, pc[31:2]};
   assign in_range  = (imem_addr < WORDS_LIMIT);
`ifdef FETCH_ZERO_HALT_EN
   assign zero_word = (imem_rd == 32'h0000_0000);
`else
   assign zero_word = 1'b0;
`endif

   // Redirect suppresses any fetch in its cycle; a pop frees a slot for a push.
   assign pop       = bus.out_valid && bus.out_ready;
   assign room      = !full || pop;
   assign fetch_try = (state == RUN) && !bus.redirect_valid;
   assign range_err = fetch_try && !in_range;
   assign zero_hit  = fetch_try && in_range && room && zero_word;
   assign push      = fetch_try && in_range && room && !zero_word;
   assign wentry    = {pc, imem_rd};

   // State register with sticky status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         fault  <= 1'b0;
         halted <= 1'b0;
      end else begin
         state  <= state_next;
         pc     <= pc_next;
         fault  <= fault_next;
         halted <= halted_next;
      end
   end

   // Next-state logic; redirect overrides every state including STOP.
   always_comb begin
      state_next = state;
      if (bus.redirect_valid) begin
         state_next = fetch_en ? RUN : IDLE;
      end else begin
         case (state)
            IDLE:    state_next = fetch_en ? RUN : IDLE;
            RUN: begin
               if (range_err || zero_hit) state_next = STOP;
               else if (!fetch_en)        state_next = IDLE;
               else                       state_next = RUN;
            end
            STOP:    state_next = STOP;
            default: state_next = IDLE;
         endcase
      end
   end

   // PC and status updates driven by the current state's decisions.
   always_comb begin
      pc_next     = pc;
      fault_next  = fault;
      halted_next = halted;
      if (bus.redirect_valid) begin
         pc_next     = word_align(bus.redirect_pc);
         fault_next  = 1'b0;
         halted_next = 1'b0;
      end else begin
         if (push)      pc_next     = pc + 32'd4;
         else           pc_next     = pc;
         if (range_err) fault_next  = 1'b1;
         else           fault_next  = fault;
         if (zero_hit)  halted_next = 1'b1;
         else           halted_next = halted;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (bus.redirect_valid),
      .push  (push),
      .pop   (pop),
      .wdata (wentry),
      .rdata (head),
      .count (fifo_count),
      .full  (full),
      .empty (empty)
   );

   assign bus.out_valid = !empty;
   assign bus.out_pc    = head.pc;
   assign bus.out_instr = head.instr;
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomised self-checking bench for imem_fetch_ctrl against a queue model.
module tb_imem_fetch_ctrl;
   localparam int DEPTH = 2;
   localparam int ST_IDLE = 0, ST_RUN = 1, ST_STOP = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic fe = 1'b0, rdy = 1'b0, rv = 1'b0;
   logic [31:0] rpc = 32'h0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] w);
      case (w)
         32'd0:   return 32'h402182B3;
         32'd1:   return 32'h00311293;
         32'd2:   return 32'h002282E3;
         32'd3:   return 32'h00000013;
         32'd4:   return 32'h00500093;
         32'd5:   return 32'h00108113;
         32'd6:   return 32'h005182E7;
         32'd7:   return 32'h00000073;
         32'd8:   return 32'h0000006F;
         default: return 32'h00000000;
      endcase
   endfunction

   imem_fetch_ctrl_if bus_a ();
   imem_fetch_ctrl_if bus_b ();
   logic [31:0] addr_a, addr_b, rd_a, rd_b;
   logic        fault_a, fault_b, halt_a, halt_b;
   logic [1:0]  cnt_a, cnt_b;

   assign rd_a = mem_word(addr_a);
   assign rd_b = mem_word(addr_b);
   assign bus_a.out_ready = rdy;      assign bus_b.out_ready = rdy;
   assign bus_a.redirect_valid = rv;  assign bus_b.redirect_valid = rv;
   assign bus_a.redirect_pc = rpc;    assign bus_b.redirect_pc = rpc;

   imem_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(DEPTH), .IMEM_WORDS(1024)) dut_a (
      .clk(clk), .reset(reset), .fetch_en(fe), .imem_addr(addr_a), .imem_rd(rd_a),
      .bus(bus_a), .fault(fault_a), .halted(halt_a), .fifo_count(cnt_a));
   imem_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(DEPTH), .IMEM_WORDS(8)) dut_b (
      .clk(clk), .reset(reset), .fetch_en(fe), .imem_addr(addr_b), .imem_rd(rd_b),
      .bus(bus_b), .fault(fault_b), .halted(halt_b), .fifo_count(cnt_b));

   // Behavioural model: index 0 is the 1024-word instance, 1 the 8-word one.
   logic [31:0] m_pc   [2];
   logic [31:0] m_qpc  [2][DEPTH];
   logic [31:0] m_qin  [2][DEPTH];
   int          m_cnt  [2];
   int          m_st   [2];
   logic        m_fault[2];
   logic        m_halt [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_pc[i] = 32'h0; m_cnt[i] = 0; m_st[i] = ST_IDLE;
         m_fault[i] = 1'b0; m_halt[i] = 1'b0;
      end
   endtask

   task automatic model_step(input int i);
      logic [31:0] words, w;
      bit stopped;
      words = (i == 0) ? 32'd1024 : 32'd8;
      if (m_cnt[i] > 0 && rdy) begin
         for (int k = 0; k < DEPTH - 1; k++) begin
            m_qpc[i][k] = m_qpc[i][k+1];
            m_qin[i][k] = m_qin[i][k+1];
         end
         m_cnt[i]--;
      end
      if (rv) begin
         m_cnt[i] = 0; m_pc[i] = rpc & 32'hFFFF_FFFC;
         m_fault[i] = 1'b0; m_halt[i] = 1'b0;
         m_st[i] = fe ? ST_RUN : ST_IDLE;
      end else if (m_st[i] == ST_IDLE) begin
         if (fe) m_st[i] = ST_RUN;
      end else if (m_st[i] == ST_RUN) begin
         stopped = 1'b0;
         if ((m_pc[i] >> 2) >= words) begin
            m_fault[i] = 1'b1; stopped = 1'b1;
         end else if (m_cnt[i] < DEPTH) begin
            w = mem_word(m_pc[i] >> 2);
`ifdef FETCH_ZERO_HALT_EN
            if (w == 32'h0) begin
               m_halt[i] = 1'b1; stopped = 1'b1;
            end
`endif
            if (!stopped) begin
               m_qpc[i][m_cnt[i]] = m_pc[i];
               m_qin[i][m_cnt[i]] = w;
               m_cnt[i]++;
               m_pc[i] = m_pc[i] + 32'd4;
            end
         end
         if (stopped) m_st[i] = ST_STOP;
         else if (!fe) m_st[i] = ST_IDLE;
      end
   endtask

   task automatic cmp_inst(input string p, input int i, input logic v, input logic [31:0] opc,
                           input logic [31:0] oin, input logic [1:0] c, input logic [31:0] a,
                           input logic f, input logic h);
      chk({p, "out_valid"},  {31'd0, v},    {31'd0, m_cnt[i] > 0});
      chk({p, "out_pc"},     opc,           (m_cnt[i] > 0) ? m_qpc[i][0] : 32'h0);
      chk({p, "out_instr"},  oin,           (m_cnt[i] > 0) ? m_qin[i][0] : 32'h0);
      chk({p, "fifo_count"}, {30'd0, c},    32'(m_cnt[i]));
      chk({p, "imem_addr"},  a,             m_pc[i] >> 2);
      chk({p, "fault"},      {31'd0, f},    {31'd0, m_fault[i]});
      chk({p, "halted"},     {31'd0, h},    {31'd0, m_halt[i]});
   endtask

   task automatic compare_all();
      cmp_inst("a.", 0, bus_a.out_valid, bus_a.out_pc, bus_a.out_instr, cnt_a, addr_a, fault_a, halt_a);
      cmp_inst("b.", 1, bus_b.out_valid, bus_b.out_pc, bus_b.out_instr, cnt_b, addr_b, fault_b, halt_b);
   endtask

   logic [31:0] last_a, last_b, instr24_a;
   bit          seen24_a, b_got20;

   // One clock: drive inputs at the falling edge, step the model, check after the rise.
   task automatic tick(input logic fe_i, input logic rdy_i, input logic rv_i, input logic [31:0] rpc_i);
      fe = fe_i; rdy = rdy_i; rv = rv_i; rpc = rpc_i;
      #1;
      if (bus_a.out_valid && rdy) begin
         last_a = bus_a.out_pc;
         if (bus_a.out_pc == 32'h24) begin
            seen24_a = 1'b1; instr24_a = bus_a.out_instr;
         end
      end
      if (bus_b.out_valid && rdy) begin
         last_b = bus_b.out_pc;
         if (bus_b.out_pc == 32'h20) b_got20 = 1'b1;
      end
      model_step(0);
      model_step(1);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   // Mid-cycle asynchronous reset; outputs must clear before any clock edge.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("async_reset_valid", {31'd0, bus_a.out_valid}, 32'd0);
      chk("async_reset_count", {30'd0, cnt_a}, 32'd0);
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      compare_all();
   endtask

   initial begin
      model_reset();
      seen24_a = 1'b0; b_got20 = 1'b0;
      last_a = 32'h0; last_b = 32'h0; instr24_a = 32'hFFFF_FFFF;
      @(negedge clk);
      reset = 1'b0;
      compare_all();
      chk("reset_out_pc", bus_a.out_pc, 32'h0);

      // Streaming from reset with decode always ready.
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      chk("first_edge_empty", {31'd0, bus_a.out_valid}, 32'd0);
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      chk("stream_pc0", bus_a.out_pc, 32'h0);
      chk("stream_in0", bus_a.out_instr, 32'h402182B3);
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      chk("stream_pc1", bus_a.out_pc, 32'h4);
      chk("stream_in1", bus_a.out_instr, 32'h00311293);
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      chk("stream_pc2", bus_a.out_pc, 32'h8);
      chk("stream_in2", bus_a.out_instr, 32'h002282E3);

      // Backpressure from the start, then release.
      do_reset();
      repeat (4) tick(1'b1, 1'b0, 1'b0, 32'h0);
      chk("bp_count", {30'd0, cnt_a}, 32'd2);
      chk("bp_pc", bus_a.out_pc, 32'h0);
      chk("bp_addr", addr_a, 32'd2);
      repeat (6) tick(1'b1, 1'b1, 1'b0, 32'h0);

      // Redirect while full, then misaligned redirect.
      repeat (3) tick(1'b1, 1'b0, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 1'b1, 32'h18);
      chk("redir_count", {30'd0, cnt_a}, 32'd0);
      chk("redir_valid", {31'd0, bus_a.out_valid}, 32'd0);
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      chk("redir_pc", bus_a.out_pc, 32'h18);
      chk("redir_in", bus_a.out_instr, 32'h005182E7);
      tick(1'b1, 1'b1, 1'b1, 32'h1A);
      chk("misalign_addr", addr_a, 32'd6);
      repeat (3) tick(1'b1, 1'b1, 1'b0, 32'h0);

      // Reset with the FIFO full, then run past the end of the program.
      repeat (4) tick(1'b1, 1'b0, 1'b0, 32'h0);
      do_reset();
      last_a = 32'h0; last_b = 32'h0; b_got20 = 1'b0; seen24_a = 1'b0;
      repeat (14) tick(1'b1, 1'b1, 1'b0, 32'h0);
      chk("range_fault", {31'd0, fault_b}, 32'd1);
      chk("range_last_pc", last_b, 32'h1C);
      chk("range_no_20", {31'd0, b_got20}, 32'd0);
`ifdef FETCH_ZERO_HALT_EN
      chk("zero_halted", {31'd0, halt_a}, 32'd1);
      chk("zero_last_pc", last_a, 32'h20);
`else
      chk("zero_seen_24", {31'd0, seen24_a}, 32'd1);
      chk("zero_instr_24", instr24_a, 32'h0);
`endif
      tick(1'b1, 1'b1, 1'b1, 32'h0);
      chk("fault_cleared", {31'd0, fault_b}, 32'd0);
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      chk("restart_valid", {31'd0, bus_b.out_valid}, 32'd1);
      chk("restart_pc", bus_b.out_pc, 32'h0);

      // Randomised traffic.
      for (int n = 0; n < 600; n++) begin
         logic [31:0] tgt;
         case ($urandom_range(0, 3))
            0:       tgt = 32'h0000_0FF4 + 32'($urandom_range(0, 7));
            1:       tgt = 32'hFFFF_FFFC;
            default: tgt = 32'($urandom_range(0, 63));
         endcase
         if ($urandom_range(0, 127) == 0) do_reset();
         tick(($urandom_range(0, 7) != 0), ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 15) == 0), tgt);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
